dual_port_regf_burst: RTL and testbench

Parametrised successor of the dual-port register file used as the I3C target/controller data buffer. It adds configurable data width, address width and depth. Each port gains a burst mode with an auto-incrementing pointer, so HDR-DDR payload bytes stream in and out without the caller driving a fresh address every cycle. Reads are registered with a valid strobe, and same-address read-during-write is write-first.

---
 rtl/regf_pkg.sv | 13 +
 rtl/regf_port_ctrl.sv | 66 ++++++
 rtl/dual_port_regf_burst.sv | 90 +++++++++
 tb/tb_dual_port_regf_burst.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/regf_pkg.sv
// Shared types and default sizing for the burst-capable dual-port register file.
package regf_pkg;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    BURST = 1'b1
  } regf_state_e;

  localparam int unsigned DATA_W_DEF = 8;
  localparam int unsigned ADDR_W_DEF = 15;
  localparam int unsigned DEPTH_DEF  = 2 ** ADDR_W_DEF;

endpackage

// File: rtl/regf_port_ctrl.sv
// Per-port access controller: IDLE/BURST FSM, auto-incrementing pointer with
// DEPTH wrap, and range check on the effective address.
module regf_port_ctrl
  import regf_pkg::*;
#(
  parameter int unsigned ADDR_W = ADDR_W_DEF,
  parameter int unsigned DEPTH  = 2 ** ADDR_W
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              en_i,
  input  logic              start_i,
  input  logic              last_i,
  input  logic [ADDR_W-1:0] addr_i,
  output logic [ADDR_W-1:0] acc_addr_o,
  output logic              acc_en_o,
  output logic              acc_err_o,
  output logic              busy_o
);

  localparam logic [ADDR_W:0]   DepthW  = (ADDR_W + 1)'(DEPTH);
  localparam logic [ADDR_W-1:0] LastIdx = ADDR_W'(DEPTH - 1);

  regf_state_e       state_q;
  logic [ADDR_W-1:0] ptr_q;
  logic              in_range;
  logic              access;

  function automatic logic [ADDR_W-1:0] ptr_inc(input logic [ADDR_W-1:0] p);
    return (p == LastIdx) ? '0 : p + 1'b1;
  endfunction

  always_comb begin
    acc_addr_o = (start_i || (state_q == IDLE)) ? addr_i : ptr_q;
    in_range   = ({1'b0, acc_addr_o} < DepthW);
    // Strobes seen while reset is asserted are discarded.
    access     = en_i && rst_ni;
    acc_en_o   = access && in_range;
    acc_err_o  = access && !in_range;
  end

  assign busy_o = (state_q == BURST);

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      ptr_q   <= '0;
    end else if (start_i) begin
      ptr_q   <= en_i ? ptr_inc(addr_i) : addr_i;
      state_q <= (en_i && last_i) ? IDLE : BURST;
    end else begin
      case (state_q)
        BURST: begin
          if (en_i) begin
            ptr_q <= ptr_inc(ptr_q);
            if (last_i) state_q <= IDLE;
          end
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: rtl/dual_port_regf_burst.sv
// Dual-port register file with per-port burst pointers, registered reads and
// write-first bypass for same-address read-during-write.
module dual_port_regf_burst
  import regf_pkg::*;
#(
  parameter int unsigned DATA_W = DATA_W_DEF,
  parameter int unsigned ADDR_W = ADDR_W_DEF,
  parameter int unsigned DEPTH  = 2 ** ADDR_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              wr_en,
  input  logic              wr_start,
  input  logic              wr_last,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] data_in,
  input  logic              rd_en,
  input  logic              rd_start,
  input  logic              rd_last,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [DATA_W-1:0] data_out,
  output logic              rd_valid,
  output logic              wr_busy,
  output logic              rd_busy,
  output logic              addr_err
);

  localparam int unsigned IdxW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [DATA_W-1:0] mem_q [DEPTH];

  logic [ADDR_W-1:0] wr_a, rd_a;
  logic              wr_acc, wr_err, rd_acc, rd_err;
  logic [DATA_W-1:0] rd_word;

  regf_port_ctrl #(
    .ADDR_W(ADDR_W),
    .DEPTH (DEPTH)
  ) u_wr_ctrl (
    .clk_i     (clk),
    .rst_ni    (reset),
    .en_i      (wr_en),
    .start_i   (wr_start),
    .last_i    (wr_last),
    .addr_i    (wr_addr),
    .acc_addr_o(wr_a),
    .acc_en_o  (wr_acc),
    .acc_err_o (wr_err),
    .busy_o    (wr_busy)
  );

  regf_port_ctrl #(
    .ADDR_W(ADDR_W),
    .DEPTH (DEPTH)
  ) u_rd_ctrl (
    .clk_i     (clk),
    .rst_ni    (reset),
    .en_i      (rd_en),
    .start_i   (rd_start),
    .last_i    (rd_last),
    .addr_i    (rd_addr),
    .acc_addr_o(rd_a),
    .acc_en_o  (rd_acc),
    .acc_err_o (rd_err),
    .busy_o    (rd_busy)
  );

  // In-range addresses are < DEPTH, so the low IdxW bits index the array exactly.
  always_ff @(posedge clk) begin
    if (wr_acc) mem_q[wr_a[IdxW-1:0]] <= data_in;
  end

  always_comb begin
    rd_word = mem_q[rd_a[IdxW-1:0]];
    if (wr_acc && (wr_a == rd_a)) rd_word = data_in;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      data_out <= '0;
      rd_valid <= 1'b0;
      addr_err <= 1'b0;
    end else begin
      rd_valid <= rd_acc;
      addr_err <= wr_err || rd_err;
      if (rd_acc) data_out <= rd_word;
    end
  end

endmodule

// File: tb/tb_dual_port_regf_burst.sv
// Directed self-checking bench; reads are scored against a queue of expected words.
module tb_dual_port_regf_burst;

  localparam int unsigned DW    = 8;
  localparam int unsigned AW    = 5;
  localparam int unsigned DEPTH = 20;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          wr_en = 1'b0, wr_start = 1'b0, wr_last = 1'b0;
  logic [AW-1:0] wr_addr = '0;
  logic [DW-1:0] data_in = '0;
  logic          rd_en = 1'b0, rd_start = 1'b0, rd_last = 1'b0;
  logic [AW-1:0] rd_addr = '0;
  logic [DW-1:0] data_out;
  logic          rd_valid, wr_busy, rd_busy, addr_err;

  dual_port_regf_burst #(
    .DATA_W(DW),
    .ADDR_W(AW),
    .DEPTH (DEPTH)
  ) dut (
    .clk     (clk),
    .reset   (reset),
    .wr_en   (wr_en),
    .wr_start(wr_start),
    .wr_last (wr_last),
    .wr_addr (wr_addr),
    .data_in (data_in),
    .rd_en   (rd_en),
    .rd_start(rd_start),
    .rd_last (rd_last),
    .rd_addr (rd_addr),
    .data_out(data_out),
    .rd_valid(rd_valid),
    .wr_busy (wr_busy),
    .rd_busy (rd_busy),
    .addr_err(addr_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [DW-1:0] d;
    int            c;
  } exp_t;

  exp_t          sbq[$];
  logic [DW-1:0] model[DEPTH];
  int            cyc = 0;
  int            vectors = 0;
  int            errors = 0;
  int            err_pulses = 0;
  logic [DW-1:0] last_rd = '0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Scoreboard: every rd_valid must match the oldest expected word in data and cycle.
  always @(negedge clk) begin
    if (addr_err === 1'b1) err_pulses++;
    if (rd_valid !== 1'b0) begin
      if (sbq.size() == 0) begin
        check("unexpected_rd_valid", 32'(rd_valid), 32'd0);
      end else begin
        exp_t e;
        e = sbq.pop_front();
        check("rd_data", 32'(data_out), 32'(e.d));
        check("rd_cycle", 32'(cyc), 32'(e.c));
      end
    end
  end

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic clr();
    wr_en = 0; wr_start = 0; wr_last = 0; wr_addr = '0; data_in = '0;
    rd_en = 0; rd_start = 0; rd_last = 0; rd_addr = '0;
  endtask

  task automatic expect_rd(input logic [DW-1:0] d);
    exp_t e;
    e.d = d;
    e.c = cyc + 1;
    sbq.push_back(e);
    last_rd = d;
  endtask

  initial begin
    int base;
    // Reset for two cycles with a dropped read strobed alongside.
    reset = 0;
    rd_en = 1; rd_addr = 5'd3;
    tick();
    check("rst_data_out", 32'(data_out), 32'd0);
    check("rst_rd_valid", 32'(rd_valid), 32'd0);
    tick();
    check("rst_busy", {30'd0, wr_busy, rd_busy}, 32'd0);
    check("rst_addr_err", 32'(addr_err), 32'd0);
    clr();
    reset = 1;

    // Legacy single write then single read.
    wr_en = 1; wr_addr = 5'd0; data_in = 8'hAA; model[0] = 8'hAA;
    tick();
    clr();
    rd_en = 1; rd_addr = 5'd0; expect_rd(model[0]);
    tick();
    clr();
    tick();
    check("hold_rd_valid", 32'(rd_valid), 32'd0);
    check("hold_data_out", 32'(data_out), 32'hAA);

    // Write burst @0x10 then read burst back; addr inputs are junk after start.
    for (int i = 0; i < 4; i++) begin
      wr_en = 1; wr_start = (i == 0); wr_last = (i == 3);
      wr_addr = (i == 0) ? 5'd16 : 5'd2;
      data_in = 8'(i + 1); model[16 + i] = 8'(i + 1);
      tick();
      check("wr_busy_burst", 32'(wr_busy), (i == 3) ? 32'd0 : 32'd1);
    end
    clr();
    for (int i = 0; i < 4; i++) begin
      rd_en = 1; rd_start = (i == 0); rd_last = (i == 3);
      rd_addr = (i == 0) ? 5'd16 : 5'd1;
      expect_rd(model[16 + i]);
      tick();
      check("rd_busy_burst", 32'(rd_busy), (i == 3) ? 32'd0 : 32'd1);
    end
    clr();
    tick();
    check("burst_idle", {30'd0, wr_busy, rd_busy}, 32'd0);

    // Wrap at DEPTH-1 -> 0 on both ports, no address error.
    base = err_pulses;
    for (int i = 0; i < 3; i++) begin
      wr_en = 1; wr_start = (i == 0); wr_last = (i == 2);
      wr_addr = (i == 0) ? 5'd18 : 5'd4;
      data_in = 8'h21 + 8'(i);
      model[(18 + i) % DEPTH] = 8'h21 + 8'(i);
      tick();
    end
    clr();
    for (int i = 0; i < 3; i++) begin
      rd_en = 1; rd_start = (i == 0); rd_last = (i == 2);
      rd_addr = (i == 0) ? 5'd18 : 5'd5;
      expect_rd(model[(18 + i) % DEPTH]);
      tick();
    end
    clr();
    tick();
    check("wrap_no_addr_err", 32'(err_pulses - base), 32'd0);

    // Out of range: write then read @25, each pulses addr_err and is dropped.
    base = err_pulses;
    wr_en = 1; wr_addr = 5'd25; data_in = 8'h55;
    tick();
    clr();
    check("oor_wr_err", 32'(addr_err), 32'd1);
    rd_en = 1; rd_addr = 5'd25;
    tick();
    clr();
    check("oor_rd_err", 32'(addr_err), 32'd1);
    check("oor_rd_valid", 32'(rd_valid), 32'd0);
    check("oor_data_hold", 32'(data_out), 32'(last_rd));
    tick();
    check("oor_err_clear", 32'(addr_err), 32'd0);
    check("oor_pulses", 32'(err_pulses - base), 32'd2);

    // Same-address read-during-write returns the new data.
    wr_en = 1; wr_addr = 5'd7; data_in = 8'h11; model[7] = 8'h11;
    tick();
    wr_en = 1; wr_addr = 5'd7; data_in = 8'hCC;
    rd_en = 1; rd_addr = 5'd7; expect_rd(8'hCC); model[7] = 8'hCC;
    tick();
    clr();
    rd_en = 1; rd_addr = 5'd7; expect_rd(model[7]);
    tick();
    clr();

    // Reset in the middle of a read burst.
    for (int i = 0; i < 4; i++) begin
      wr_en = 1; wr_start = (i == 0); wr_last = (i == 3); wr_addr = 5'd8;
      data_in = 8'h31 + 8'(i); model[8 + i] = 8'h31 + 8'(i);
      tick();
    end
    clr();
    for (int i = 0; i < 2; i++) begin
      rd_en = 1; rd_start = (i == 0); rd_addr = 5'd8;
      expect_rd(model[8 + i]);
      tick();
    end
    check("mid_rd_busy", 32'(rd_busy), 32'd1);
    reset = 0; rd_start = 0; rd_en = 1;
    tick();
    check("mid_rst_rd_busy", 32'(rd_busy), 32'd0);
    check("mid_rst_data_out", 32'(data_out), 32'd0);
    reset = 1; rd_en = 1; rd_addr = 5'd11; expect_rd(model[11]);
    tick();
    rd_en = 1; rd_addr = 5'd10; expect_rd(model[10]);
    tick();
    clr();
    tick();
    check("post_rst_rd_busy", 32'(rd_busy), 32'd0);
    tick();
    check("scoreboard_drained", 32'(sbq.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
